alu_8bit: RTL and testbench

- 8-bit registered ALU with eight operations selected by a 3-bit opcode.
- Produces an 8-bit result plus sign, zero, carry, parity and overflow status flags.
- Sits in the datapath as a single-cycle-latency execution unit; result and flags are captured in output registers.

---
 rtl/alu_pkg.sv | 26 ++
 rtl/alu_8bit_core.sv | 67 ++++++
 rtl/alu_8bit.sv | 57 +++++
 tb/tb_alu_8bit.sv | 139 +++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - opcode encoding and status flag layout shared by the ALU files
package alu_pkg;

   typedef enum logic [2:0] {
      OP_ADD = 3'b000,
      OP_SUB = 3'b001,
      OP_AND = 3'b010,
      OP_OR  = 3'b011,
      OP_XOR = 3'b100,
      OP_NOT = 3'b101,
      OP_SHL = 3'b110,
      OP_SHR = 3'b111
   } alu_op_e;

   // Packed order, MSB first: sign, zero, carry, parity, overflow
   typedef struct packed {
      logic sign;
      logic zero;
      logic carry;
      logic parity;
      logic overflow;
   } alu_flags_t;

   localparam alu_flags_t FLAGS_CLEAR = '{default: 1'b0};

endpackage

// File: rtl/alu_8bit_core.sv
// rtl/alu_8bit_core.sv - combinational ALU datapath: operands and opcode to result and flags
module alu_8bit_core
   import alu_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  alu_op_e          opcode,
   output logic [WIDTH-1:0] result,
   output alu_flags_t       flags
);

   logic [WIDTH:0] sum;
   logic [WIDTH:0] diff;
   logic           carry;
   logic           overflow;

   // Extra top bit of diff is the borrow, set exactly when a < b unsigned
   assign sum  = {1'b0, a} + {1'b0, b};
   assign diff = {1'b0, a} - {1'b0, b};

   always_comb begin
      result   = '0;
      carry    = 1'b0;
      overflow = 1'b0;
      unique case (opcode)
         OP_ADD: begin
            result   = sum[WIDTH-1:0];
            carry    = sum[WIDTH];
            overflow = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
         end
         OP_SUB: begin
            result   = diff[WIDTH-1:0];
            carry    = diff[WIDTH];
            overflow = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
         end
         OP_AND: result = a & b;
         OP_OR:  result = a | b;
         OP_XOR: result = a ^ b;
         OP_NOT: result = ~a;
         OP_SHL: begin
            result = {a[WIDTH-2:0], 1'b0};
            carry  = a[WIDTH-1];
         end
         OP_SHR: begin
            result = {1'b0, a[WIDTH-1:1]};
            carry  = a[0];
         end
         default: begin
            result   = '0;
            carry    = 1'b0;
            overflow = 1'b0;
         end
      endcase
   end

   always_comb begin
      flags          = FLAGS_CLEAR;
      flags.sign     = result[WIDTH-1];
      flags.zero     = (result == '0);
      flags.carry    = carry;
      flags.parity   = ~^result;
      flags.overflow = overflow;
   end

endmodule

// File: rtl/alu_8bit.sv
// rtl/alu_8bit.sv - registered single-cycle ALU: core datapath plus output and valid registers
module alu_8bit
   import alu_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [2:0]       opcode,
   output logic             out_valid,
   output logic [WIDTH-1:0] out,
   output logic             sign,
   output logic             zero,
   output logic             carry,
   output logic             parity,
   output logic             overflow
);

   logic [WIDTH-1:0] core_result;
   alu_flags_t       core_flags;
   alu_flags_t       flags_q;

   alu_8bit_core #(
      .WIDTH (WIDTH)
   ) u_core (
      .a      (a),
      .b      (b),
      .opcode (alu_op_e'(opcode)),
      .result (core_result),
      .flags  (core_flags)
   );

   // Result and flags only load on accepted operations, otherwise they hold
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid <= 1'b0;
         out       <= '0;
         flags_q   <= FLAGS_CLEAR;
      end else begin
         out_valid <= in_valid;
         if (in_valid) begin
            out     <= core_result;
            flags_q <= core_flags;
         end
      end
   end

   assign sign     = flags_q.sign;
   assign zero     = flags_q.zero;
   assign carry    = flags_q.carry;
   assign parity   = flags_q.parity;
   assign overflow = flags_q.overflow;

endmodule

// File: tb/tb_alu_8bit.sv
// tb/tb_alu_8bit.sv - directed self-checking bench for alu_8bit
module tb_alu_8bit;

   logic       clk;
   logic       rst;
   logic       in_valid;
   logic [7:0] a;
   logic [7:0] b;
   logic [2:0] opcode;
   logic       out_valid;
   logic [7:0] out;
   logic       sign;
   logic       zero;
   logic       carry;
   logic       parity;
   logic       overflow;

   int total = 0;
   int bad   = 0;

   alu_8bit dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .a         (a),
      .b         (b),
      .opcode    (opcode),
      .out_valid (out_valid),
      .out       (out),
      .sign      (sign),
      .zero      (zero),
      .carry     (carry),
      .parity    (parity),
      .overflow  (overflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Expected flags given as {sign, zero, carry, parity, overflow}
   task automatic chk_all(input string tag, input logic v, input logic [7:0] o, input logic [4:0] f);
      chk({tag, "_valid"}, {7'd0, out_valid}, {7'd0, v});
      chk({tag, "_out"}, out, o);
      chk({tag, "_flags"}, {3'd0, sign, zero, carry, parity, overflow}, {3'd0, f});
   endtask

   task automatic drive(input logic [2:0] op, input logic [7:0] x, input logic [7:0] y);
      @(negedge clk);
      in_valid = 1'b1;
      opcode   = op;
      a        = x;
      b        = y;
   endtask

   task automatic op_check(input string tag, input logic [2:0] op, input logic [7:0] x,
                           input logic [7:0] y, input logic [7:0] o, input logic [4:0] f);
      drive(op, x, y);
      @(posedge clk);
      #1;
      chk_all(tag, 1'b1, o, f);
   endtask

   initial begin
      rst      = 1'b1;
      in_valid = 1'b0;
      a        = 8'h00;
      b        = 8'h00;
      opcode   = 3'b000;
      repeat (2) @(posedge clk);
      #1;
      chk_all("reset", 1'b0, 8'h00, 5'b00000);
      @(negedge clk);
      rst = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk_all("post_reset_idle", 1'b0, 8'h00, 5'b00000);

      // Back-to-back sweep, a=5 b=11
      op_check("add_5_11", 3'b000, 8'd5, 8'd11, 8'h10, 5'b00000);
      op_check("sub_5_11", 3'b001, 8'd5, 8'd11, 8'hFA, 5'b10110);
      op_check("and_5_11", 3'b010, 8'd5, 8'd11, 8'h01, 5'b00000);
      op_check("or_5_11",  3'b011, 8'd5, 8'd11, 8'h0F, 5'b00010);
      op_check("xor_5_11", 3'b100, 8'd5, 8'd11, 8'h0E, 5'b00000);
      op_check("not_5",    3'b101, 8'd5, 8'd11, 8'hFA, 5'b10010);
      op_check("shl_5",    3'b110, 8'd5, 8'd11, 8'h0A, 5'b00010);
      op_check("shr_5",    3'b111, 8'd5, 8'd11, 8'h02, 5'b00100);

      op_check("add_7f_01", 3'b000, 8'h7F, 8'h01, 8'h80, 5'b10001);
      op_check("add_ff_01", 3'b000, 8'hFF, 8'h01, 8'h00, 5'b01110);
      op_check("sub_80_01", 3'b001, 8'h80, 8'h01, 8'h7F, 5'b00001);
      op_check("sub_03_03", 3'b001, 8'h03, 8'h03, 8'h00, 5'b01010);
      op_check("shl_81",    3'b110, 8'h81, 8'h00, 8'h02, 5'b00100);
      op_check("and_f0_3c", 3'b010, 8'hF0, 8'h3C, 8'h30, 5'b00010);

      // Hold: in_valid low with changing operands keeps the last result
      @(negedge clk);
      in_valid = 1'b0;
      a        = 8'hFF;
      b        = 8'hFF;
      opcode   = 3'b000;
      @(posedge clk);
      #1;
      chk_all("hold_1", 1'b0, 8'h30, 5'b00010);
      @(negedge clk);
      a      = 8'h00;
      opcode = 3'b101;
      @(posedge clk);
      #1;
      chk_all("hold_2", 1'b0, 8'h30, 5'b00010);

      // Asynchronous reset between edges, with a pending valid operation
      drive(3'b000, 8'h7F, 8'h01);
      #2;
      rst = 1'b1;
      #1;
      chk_all("async_reset", 1'b0, 8'h00, 5'b00000);
      @(posedge clk);
      #1;
      chk_all("reset_wins", 1'b0, 8'h00, 5'b00000);
      @(negedge clk);
      rst      = 1'b0;
      in_valid = 1'b0;
      @(posedge clk);
      #1;
      chk_all("reset_discard", 1'b0, 8'h00, 5'b00000);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
